// File: rtl/net_bus_tx_fork.sv
// One-beat eager fork: a held beat is offered to every channel in its mask and retires per channel.
// Latency 1 cycle accept-to-WVALID; READY = idle or last pending channel accepting this cycle.
module net_bus_tx_fork #(
  parameter int DATA_WIDTH = 4,
  parameter int PORTS      = 4,
  localparam int W         = DATA_WIDTH * 9 + 14
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic [W-1:0]       DATA,
  input  logic [PORTS-1:0]   MASK,
  input  logic               VALID,
  output logic               READY,
  output logic [PORTS-1:0]   WCLK,
  output logic [PORTS*W-1:0] WDATA,
  output logic [PORTS-1:0]   WVALID,
  input  logic [PORTS-1:0]   WREADY,
  output logic               DROP,
  output logic [15:0]        BEAT_CNT
);

  logic [W-1:0]     r_hdata;
  logic [PORTS-1:0] r_pending;
  logic             r_drop;
  logic [15:0]      r_cnt;

  logic [PORTS-1:0] w_acc;
  logic [PORTS-1:0] w_rem;
  logic             w_busy;
  logic             w_last;
  logic             w_take;
  logic             w_mask_nz;

  assign w_acc     = r_pending & WREADY;
  assign w_rem     = r_pending & ~w_acc;
  assign w_busy    = |r_pending;
  assign w_last    = w_busy & (w_rem == '0);
  assign w_mask_nz = |MASK;

  // Ready looks through the channel handshakes so back-to-back beats have no bubble.
  assign READY  = ~w_busy | w_last;
  assign w_take = VALID & READY;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_hdata   <= '0;
      r_pending <= '0;
      r_drop    <= 1'b0;
      r_cnt     <= 16'd0;
    end else begin
      if (w_take && w_mask_nz) begin
        r_hdata   <= DATA;
        r_pending <= MASK;
      end else begin
        r_pending <= w_rem;
      end
      r_drop <= w_take & ~w_mask_nz;
      if (w_last) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign WCLK     = {PORTS{CLK}};
  assign WDATA    = {PORTS{r_hdata}};
  assign WVALID   = r_pending;
  assign DROP     = r_drop;
  assign BEAT_CNT = r_cnt;

endmodule

// File: tb/tb_net_bus_tx_fork.sv
// Scoreboard bench for net_bus_tx_fork (PORTS=4): per-channel expected-beat queues filled at acceptance.
module tb_net_bus_tx_fork;
  localparam int DW = 4;
  localparam int P  = 4;
  localparam int W  = DW * 9 + 14;

  logic           CLK;
  logic           RESETN;
  logic [W-1:0]   DATA;
  logic [P-1:0]   MASK;
  logic           VALID;
  logic           READY;
  logic [P-1:0]   WCLK;
  logic [P*W-1:0] WDATA;
  logic [P-1:0]   WVALID;
  logic [P-1:0]   WREADY;
  logic           DROP;
  logic [15:0]    BEAT_CNT;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q [P][$];

  net_bus_tx_fork #(.DATA_WIDTH(DW), .PORTS(P)) dut (
    .CLK(CLK), .RESETN(RESETN), .DATA(DATA), .MASK(MASK), .VALID(VALID),
    .READY(READY), .WCLK(WCLK), .WDATA(WDATA), .WVALID(WVALID),
    .WREADY(WREADY), .DROP(DROP), .BEAT_CNT(BEAT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_beat();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[W-1:0];
  endfunction

  // Every channel handshake must retire the oldest beat queued for that channel.
  always @(negedge CLK) begin
    if (RESETN === 1'b1) begin
      for (int i = 0; i < P; i++) begin
        if (WVALID[i] === 1'b1) begin
          chk("vld_has_beat", 64'(exp_q[i].size() != 0), 64'd1);
          if (WREADY[i] === 1'b1 && exp_q[i].size() != 0)
            chk("wdata", 64'(WDATA[i*W +: W]), 64'(exp_q[i].pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_beat(input logic [W-1:0] d, input logic [P-1:0] m);
    for (int i = 0; i < P; i++)
      if (m[i]) exp_q[i].push_back(d);
  endtask

  // Present a beat, wait (bounded) for READY, record it; returns just after the accepting edge.
  task automatic drive_beat(input logic [W-1:0] d, input logic [P-1:0] m);
    bit ok;
    ok = 1'b0;
    VALID = 1'b1;
    DATA  = d;
    MASK  = m;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge CLK);
      if (READY === 1'b1) ok = 1'b1;
      else tick();
    end
    if (ok) push_beat(d, m);
    else chk("ready_timeout", 64'd0, 64'd1);
    tick();
    VALID = 1'b0;
    DATA  = rnd_beat();
  endtask

  logic [W-1:0] beats [3];
  logic [W-1:0] bc;

  initial begin
    RESETN = 1'b0;
    VALID  = 1'b0;
    DATA   = '0;
    MASK   = '0;
    WREADY = '0;
    repeat (2) tick();
    @(negedge CLK);
    chk("rst_wvalid", 64'(WVALID), 64'd0);
    chk("rst_wdata",  64'(WDATA[W-1:0]), 64'd0);
    chk("rst_ready",  64'(READY), 64'd1);
    chk("rst_cnt",    64'(BEAT_CNT), 64'd0);
    chk("rst_drop",   64'(DROP), 64'd0);
    tick();

    // Broadcast, all ready; accepted in first cycle out of reset.
    RESETN = 1'b1;
    WREADY = 4'hF;
    drive_beat(rnd_beat(), 4'hF);
    @(negedge CLK);
    chk("bc_wvalid", 64'(WVALID), 64'hF);
    chk("bc_ready",  64'(READY), 64'd1);
    tick();
    @(negedge CLK);
    chk("bc_idle", 64'(WVALID), 64'd0);
    chk("bc_cnt",  64'(BEAT_CNT), 64'd1);
    tick();

    // Split completion: even channels first, odd channels next cycle.
    WREADY = 4'b0101;
    drive_beat(rnd_beat(), 4'hF);
    @(negedge CLK);
    chk("split_wvalid1", 64'(WVALID), 64'hF);
    chk("split_ready1",  64'(READY), 64'd0);
    tick();
    WREADY = 4'b1010;
    @(negedge CLK);
    chk("split_wvalid2", 64'(WVALID), 64'hA);
    chk("split_ready2",  64'(READY), 64'd1);
    tick();
    @(negedge CLK);
    chk("split_idle", 64'(WVALID), 64'd0);
    chk("split_cnt",  64'(BEAT_CNT), 64'd2);
    tick();

    // Single destination stalled 5 cycles while inputs churn.
    WREADY = 4'h0;
    bc = rnd_beat();
    drive_beat(bc, 4'b0010);
    for (int k = 0; k < 6; k++) begin
      if (k < 5) begin
        VALID = ((k % 2) == 1);
        DATA  = rnd_beat();
        MASK  = 4'hF;
      end else begin
        VALID  = 1'b0;
        WREADY = 4'hF;
      end
      @(negedge CLK);
      chk("stall_wvalid", 64'(WVALID), 64'h2);
      chk("stall_wdata",  64'(WDATA[W +: W]), 64'(bc));
      chk("stall_ready",  64'(READY), (k == 5) ? 64'd1 : 64'd0);
      tick();
    end
    @(negedge CLK);
    chk("stall_idle", 64'(WVALID), 64'd0);
    chk("stall_cnt",  64'(BEAT_CNT), 64'd3);
    tick();

    // Zero mask drops the beat.
    drive_beat(rnd_beat(), 4'h0);
    @(negedge CLK);
    chk("drop_pulse",  64'(DROP), 64'd1);
    chk("drop_wvalid", 64'(WVALID), 64'd0);
    tick();
    @(negedge CLK);
    chk("drop_clear", 64'(DROP), 64'd0);
    chk("drop_cnt",   64'(BEAT_CNT), 64'd3);
    tick();

    // Back-to-back broadcast beats, no bubble.
    WREADY = 4'hF;
    for (int b = 0; b < 3; b++) begin
      beats[b] = rnd_beat();
      VALID = 1'b1;
      DATA  = beats[b];
      MASK  = 4'hF;
      @(negedge CLK);
      chk("b2b_ready", 64'(READY), 64'd1);
      if (b > 0) chk("b2b_wvalid", 64'(WVALID), 64'hF);
      push_beat(beats[b], 4'hF);
      tick();
    end
    VALID = 1'b0;
    @(negedge CLK);
    chk("b2b_wvalid_last", 64'(WVALID), 64'hF);
    tick();
    @(negedge CLK);
    chk("b2b_idle", 64'(WVALID), 64'd0);
    chk("b2b_cnt",  64'(BEAT_CNT), 64'd6);
    tick();

    // Reset while a beat is held discards it.
    WREADY = 4'h0;
    drive_beat(rnd_beat(), 4'h3);
    @(negedge CLK);
    chk("mid_wvalid", 64'(WVALID), 64'h3);
    tick();
    RESETN = 1'b0;
    for (int i = 0; i < P; i++) exp_q[i].delete();
    tick();
    RESETN = 1'b1;
    @(negedge CLK);
    chk("mid_rst_wvalid", 64'(WVALID), 64'd0);
    chk("mid_rst_cnt",    64'(BEAT_CNT), 64'd0);
    chk("mid_rst_ready",  64'(READY), 64'd1);
    chk("mid_rst_wdata",  64'(WDATA[W-1:0]), 64'd0);
    tick();
    WREADY = 4'hF;
    drive_beat(rnd_beat(), 4'hF);
    @(negedge CLK);
    chk("post_wvalid", 64'(WVALID), 64'hF);
    tick();
    @(negedge CLK);
    chk("post_cnt", 64'(BEAT_CNT), 64'd1);
    tick();

    for (int i = 0; i < P; i++)
      chk("queue_drained", 64'(exp_q[i].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/net_bus_tx_fork.md
NET_BUS_TX_FORK -- requirements
Module: net_bus_tx_fork

Interface
REQ-001 Parameter DATA_WIDTH, default 4, lane count; beat width W = DATA_WIDTH*9+14.
REQ-002 Parameter PORTS, default 4, number of output channels, legal range 2..16.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RESETN  in  1  reset, synchronous, active-low.
REQ-005 DATA  in  W  input beat.
REQ-006 MASK  in  PORTS  destination bitmask, sampled with DATA; all-ones = broadcast.
REQ-007 VALID  in  1  input beat valid.
REQ-008 READY  out  1  input beat accepted when VALID & READY.
REQ-009 WCLK  out  PORTS  per-channel clock; every bit driven directly from CLK.
REQ-010 WDATA  out  PORTS*W  per-channel beat; channel i occupies bits [i*W +: W].
REQ-011 WVALID  out  PORTS  per-channel valid.
REQ-012 WREADY  in  PORTS  per-channel ready.
REQ-013 DROP  out  1  one-cycle pulse when an accepted beat has MASK = 0.
REQ-014 BEAT_CNT  out  16  count of completed, non-dropped beats.

Function
REQ-015 The block SHALL hold one beat: register HDATA (W bits) and PENDING mask (PORTS bits); busy = |PENDING.
REQ-016 Every WDATA slice SHALL equal HDATA.
REQ-017 WVALID[i] SHALL equal PENDING[i]; non-destination channels never see WVALID.
REQ-018 Channel handshake: acc[i] = WVALID[i] & WREADY[i]; each cycle, PENDING <= PENDING & ~acc (eager fork: each channel completes independently, no re-send to a channel that has accepted).
REQ-019 last = busy & ((PENDING & ~acc) == 0).
REQ-020 READY SHALL equal !busy | last (combinational from WREADY; no bubble between back-to-back beats).
REQ-021 On VALID & READY with MASK != 0: HDATA <= DATA, PENDING <= MASK, overriding REQ-018 in the same cycle.
REQ-022 On VALID & READY with MASK = 0: HDATA and PENDING unchanged by the input (REQ-018 still applies); DROP = 1 next cycle; BEAT_CNT unchanged.
REQ-023 Latency: beat accepted in cycle n SHALL present WVALID in cycle n+1.
REQ-024 WVALID[i] once high SHALL stay high with WDATA stable until acc[i]; VALID/DATA/MASK changes do not affect held beat.
REQ-025 BEAT_CNT SHALL increment by 1 in the cycle after last = 1; wraps 0xFFFF -> 0x0000.
REQ-026 Simultaneous last and new acceptance SHALL both take effect: count increments, new beat loaded.
REQ-027 WREADY[i] while WVALID[i] = 0 SHALL be ignored.
REQ-028 MASK bits are not validated beyond REQ-022; any non-zero pattern is legal.

Reset
REQ-029 With RESETN = 0 at a rising edge: PENDING = 0, HDATA = 0, DROP = 0, BEAT_CNT = 0.
REQ-030 During and after reset: WVALID = 0, WDATA = 0, READY = 1 (combinationally from PENDING = 0).
REQ-031 Reset mid-transfer SHALL discard the held beat without completing it; BEAT_CNT not incremented.
REQ-032 First acceptance is possible in the first cycle with RESETN = 1.

Verification
REQ-033 PORTS=4: broadcast MASK=4'hF, DATA=A, all WREADY=1 -> WVALID=4'hF for exactly 1 cycle, WDATA slices = A, BEAT_CNT=1, READY never low.
REQ-034 MASK=4'hF, WREADY=4'b0101 for cycle 1 then 4'b1010 -> WVALID 4'hF then 4'hA, then 0; READY high only in the second cycle; no duplicate on channels 0/2.
REQ-035 MASK=4'b0010, WREADY=0 for 5 cycles then 1 -> only WVALID[1] high for 6 cycles, WDATA stable, DATA input toggling ignored, BEAT_CNT +1.
REQ-036 VALID with MASK=0 -> READY=1, DROP pulses one cycle, all WVALID stay 0, BEAT_CNT unchanged.
REQ-037 Back-to-back beats A,B,C, MASK=4'hF, all WREADY=1 -> outputs A,B,C on consecutive cycles, READY continuously 1, BEAT_CNT=3.
REQ-038 Beat held with WVALID=4'h3, RESETN=0 one cycle -> WVALID=0, BEAT_CNT=0, READY=1; next beat delivered normally.
